vga_mode_ctrl: RTL and testbench

Video mode controller sitting between top-level configuration and vga_core/vga_test_gen in the pxl_clk domain. Accepts mode-change requests and drives the full timing parameter set to vga_core from a fixed table of modes legal at 25.175 MHz. Switches glitch-free: wait for end of frame, blank RGB for N frames, reset vga_core with the new timing loaded, run one blanked frame, then unblank and acknowledge.

---
 rtl/vga_modes_pkg.sv | 84 ++++++++
 rtl/vga_mode_rom.sv | 13 +
 rtl/vga_mode_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_modes_pkg.sv
// Shared mode indices, timing constants, FSM encoding and the mode table
// for the 25.175 MHz video mode controller.
package vga_modes_pkg;

    localparam logic [1:0] MODE_640X480 = 2'd0;
    localparam logic [1:0] MODE_640X400 = 2'd1;
    localparam logic [1:0] MODE_640X350 = 2'd2;
    localparam logic [1:0] MODE_INVALID = 2'd3;

    localparam logic [3:0] BLANK = 4'h0;

    // Horizontal timing and vertical sync width are common to every mode.
    localparam logic [31:0] H_RES   = 32'd640;
    localparam logic [31:0] H_FRONT = 32'd16;
    localparam logic [31:0] H_BACK  = 32'd48;
    localparam logic [31:0] H_SYNC  = 32'd96;
    localparam logic [31:0] V_SYNC  = 32'd2;

    localparam logic [31:0] V480_RES   = 32'd480;
    localparam logic [31:0] V480_FRONT = 32'd10;
    localparam logic [31:0] V480_BACK  = 32'd33;

    localparam logic [31:0] V400_RES   = 32'd400;
    localparam logic [31:0] V400_FRONT = 32'd12;
    localparam logic [31:0] V400_BACK  = 32'd35;

    localparam logic [31:0] V350_RES   = 32'd350;
    localparam logic [31:0] V350_FRONT = 32'd37;
    localparam logic [31:0] V350_BACK  = 32'd60;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EOF,
        ST_BLANK,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN_IN
    } state_e;

    typedef struct packed {
        logic [31:0] horz_res;
        logic [31:0] horz_front;
        logic [31:0] horz_back;
        logic [31:0] horz_sync_len;
        logic [31:0] vert_res;
        logic [31:0] vert_front;
        logic [31:0] vert_back;
        logic [31:0] vert_sync_len;
        logic        hsync_pol;
        logic        vsync_pol;
    } timing_t;

    // The invalid index falls back to the 640x480 set; callers gate it with the valid flag.
    function automatic timing_t mode_timing(input logic [1:0] idx);
        timing_t t;
        t.horz_res      = H_RES;
        t.horz_front    = H_FRONT;
        t.horz_back     = H_BACK;
        t.horz_sync_len = H_SYNC;
        t.vert_res      = V480_RES;
        t.vert_front    = V480_FRONT;
        t.vert_back     = V480_BACK;
        t.vert_sync_len = V_SYNC;
        t.hsync_pol     = 1'b1;
        t.vsync_pol     = 1'b1;
        case (idx)
            MODE_640X400: begin
                t.vert_res   = V400_RES;
                t.vert_front = V400_FRONT;
                t.vert_back  = V400_BACK;
                t.vsync_pol  = 1'b0;
            end
            MODE_640X350: begin
                t.vert_res   = V350_RES;
                t.vert_front = V350_FRONT;
                t.vert_back  = V350_BACK;
                t.hsync_pol  = 1'b0;
            end
            default: ;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode index -> timing-set lookup with a valid flag.
module vga_mode_rom
    import vga_modes_pkg::*;
(
    input  logic [1:0] mode_idx,
    output timing_t    timing,
    output logic       valid
);

    assign timing = mode_timing(mode_idx);
    assign valid  = (mode_idx != MODE_INVALID);

endmodule

// File: rtl/vga_mode_ctrl.sv
// Video mode controller: accepts mode-change requests and switches vga_core
// timing glitch-free (wait end of frame, blank, reload under reset, run-in).
module vga_mode_ctrl
    import vga_modes_pkg::*;
#(
    parameter logic [1:0]  DEFAULT_MODE  = MODE_640X480,
    parameter int unsigned BLANK_FRAMES  = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned EOF_TIMEOUT   = 1000000
) (
    input  logic        pxl_clk,
    input  logic        pxl_rst,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    output logic        mode_ack,
    output logic        mode_nack,
    output logic        mode_busy,
    output logic [1:0]  cur_mode,
    input  logic        vert_active,
    input  logic [3:0]  rgb_red_in,
    input  logic [3:0]  rgb_green_in,
    input  logic [3:0]  rgb_blue_in,
    output logic [3:0]  rgb_red,
    output logic [3:0]  rgb_green,
    output logic [3:0]  rgb_blue,
    output logic [31:0] horz_res,
    output logic [31:0] horz_front,
    output logic [31:0] horz_back,
    output logic [31:0] horz_sync_len,
    output logic [31:0] vert_res,
    output logic [31:0] vert_front,
    output logic [31:0] vert_back,
    output logic [31:0] vert_sync_len,
    output logic        hsync_pol,
    output logic        vsync_pol,
    output logic        core_rst
);

    localparam logic [3:0]  FRAME_LAST   = 4'(BLANK_FRAMES - 1);
    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(EOF_TIMEOUT - 1);
    localparam timing_t     RESET_TIMING = mode_timing(DEFAULT_MODE);

    state_e      state_q, state_d;
    logic [1:0]  next_mode_q, next_mode_d;
    logic [1:0]  cur_mode_q, cur_mode_d;
    timing_t     timing_q, timing_d;
    logic        blank_q, blank_d;
    logic        ack_q, ack_d;
    logic        nack_q, nack_d;
    logic        busy_q, busy_d;
    logic        int_rst_q, int_rst_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [19:0] tmo_cnt_q, tmo_cnt_d;
    logic        va_q;
    logic        eof;

    logic [1:0]  rom_idx;
    timing_t     rom_timing;
    logic        rom_valid;

    // The ROM validates incoming requests in IDLE and supplies the new set in LOAD.
    assign rom_idx = (state_q == ST_LOAD) ? next_mode_q : mode_sel;

    vga_mode_rom u_rom (
        .mode_idx (rom_idx),
        .timing   (rom_timing),
        .valid    (rom_valid)
    );

    assign eof = va_q & ~vert_active;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        next_mode_d  = next_mode_q;
        cur_mode_d   = cur_mode_q;
        timing_d     = timing_q;
        blank_d      = blank_q;
        ack_d        = 1'b0;
        nack_d       = 1'b0;
        busy_d       = busy_q;
        int_rst_d    = int_rst_q;
        frame_cnt_d  = frame_cnt_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;

        if (mode_req && busy_q) begin
            nack_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (mode_req) begin
                    if (!rom_valid) begin
                        nack_d = 1'b1;
                    end else if (mode_sel == cur_mode_q) begin
                        ack_d = 1'b1;
                    end else begin
                        next_mode_d = mode_sel;
                        busy_d      = 1'b1;
                        tmo_cnt_d   = '0;
                        state_d     = ST_WAIT_EOF;
                    end
                end
            end
            ST_WAIT_EOF: begin
                if (eof) begin
                    blank_d     = 1'b1;
                    frame_cnt_d = '0;
                    state_d     = ST_BLANK;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    blank_d = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 20'd1;
                end
            end
            ST_BLANK: begin
                if (eof) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            ST_LOAD: begin
                timing_d     = rom_timing;
                cur_mode_d   = next_mode_q;
                int_rst_d    = 1'b1;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    int_rst_d = 1'b0;
                    state_d   = ST_RUN_IN;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_RUN_IN: begin
                if (eof) begin
                    blank_d = 1'b0;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pxl_clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (pxl_rst) begin
            state_q      <= ST_IDLE;
            next_mode_q  <= DEFAULT_MODE;
            cur_mode_q   <= DEFAULT_MODE;
            timing_q     <= RESET_TIMING;
            blank_q      <= 1'b0;
            ack_q        <= 1'b0;
            nack_q       <= 1'b0;
            busy_q       <= 1'b0;
            int_rst_q    <= 1'b0;
            frame_cnt_q  <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            va_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_mode_q  <= next_mode_d;
            cur_mode_q   <= cur_mode_d;
            timing_q     <= timing_d;
            blank_q      <= blank_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
            busy_q       <= busy_d;
            int_rst_q    <= int_rst_d;
            frame_cnt_q  <= frame_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            va_q         <= vert_active;
        end
    end

    assign mode_ack  = ack_q;
    assign mode_nack = nack_q;
    assign mode_busy = busy_q;
    assign cur_mode  = cur_mode_q;
    assign core_rst  = pxl_rst | int_rst_q;

    assign rgb_red   = blank_q ? BLANK : rgb_red_in;
    assign rgb_green = blank_q ? BLANK : rgb_green_in;
    assign rgb_blue  = blank_q ? BLANK : rgb_blue_in;

    assign horz_res      = timing_q.horz_res;
    assign horz_front    = timing_q.horz_front;
    assign horz_back     = timing_q.horz_back;
    assign horz_sync_len = timing_q.horz_sync_len;
    assign vert_res      = timing_q.vert_res;
    assign vert_front    = timing_q.vert_front;
    assign vert_back     = timing_q.vert_back;
    assign vert_sync_len = timing_q.vert_sync_len;
    assign hsync_pol     = timing_q.hsync_pol;
    assign vsync_pol     = timing_q.vsync_pol;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Self-checking bench for vga_mode_ctrl: random frame lengths and pixel data,
// expectations derived from the recorded end-of-frame events and the mode table.
module tb_vga_mode_ctrl;

    localparam int BLANK_N   = 2;
    localparam int SETTLE_N  = 16;
    localparam int TIMEOUT_N = 300;

    logic        pxl_clk = 1'b0;
    logic        pxl_rst;
    logic [1:0]  mode_sel;
    logic        mode_req;
    logic        mode_ack, mode_nack, mode_busy;
    logic [1:0]  cur_mode;
    logic        vert_active;
    logic [3:0]  rgb_red_in, rgb_green_in, rgb_blue_in;
    logic [3:0]  rgb_red, rgb_green, rgb_blue;
    logic [31:0] horz_res, horz_front, horz_back, horz_sync_len;
    logic [31:0] vert_res, vert_front, vert_back, vert_sync_len;
    logic        hsync_pol, vsync_pol, core_rst;

    vga_mode_ctrl #(
        .DEFAULT_MODE  (2'd0),
        .BLANK_FRAMES  (BLANK_N),
        .SETTLE_CYCLES (SETTLE_N),
        .EOF_TIMEOUT   (TIMEOUT_N)
    ) dut (
        .pxl_clk       (pxl_clk),
        .pxl_rst       (pxl_rst),
        .mode_sel      (mode_sel),
        .mode_req      (mode_req),
        .mode_ack      (mode_ack),
        .mode_nack     (mode_nack),
        .mode_busy     (mode_busy),
        .cur_mode      (cur_mode),
        .vert_active   (vert_active),
        .rgb_red_in    (rgb_red_in),
        .rgb_green_in  (rgb_green_in),
        .rgb_blue_in   (rgb_blue_in),
        .rgb_red       (rgb_red),
        .rgb_green     (rgb_green),
        .rgb_blue      (rgb_blue),
        .horz_res      (horz_res),
        .horz_front    (horz_front),
        .horz_back     (horz_back),
        .horz_sync_len (horz_sync_len),
        .vert_res      (vert_res),
        .vert_front    (vert_front),
        .vert_back     (vert_back),
        .vert_sync_len (vert_sync_len),
        .hsync_pol     (hsync_pol),
        .vsync_pol     (vsync_pol),
        .core_rst      (core_rst)
    );

    always #20 pxl_clk = ~pxl_clk;

    // Mode table: hres/hfront/hback/hsync, vres/vfront/vback/vsync, hpol, vpol.
    logic [31:0] exp_tab [3][10] = '{
        '{640, 16, 48, 96, 480, 10, 33, 2, 1, 1},
        '{640, 16, 48, 96, 400, 12, 35, 2, 1, 0},
        '{640, 16, 48, 96, 350, 37, 60, 2, 0, 1}
    };
    string fld_name [10] = '{"horz_res", "horz_front", "horz_back", "horz_sync_len",
                             "vert_res", "vert_front", "vert_back", "vert_sync_len",
                             "hsync_pol", "vsync_pol"};
    logic [31:0] obs_tab [10];

    always_comb begin
        obs_tab[0] = horz_res;
        obs_tab[1] = horz_front;
        obs_tab[2] = horz_back;
        obs_tab[3] = horz_sync_len;
        obs_tab[4] = vert_res;
        obs_tab[5] = vert_front;
        obs_tab[6] = vert_back;
        obs_tab[7] = vert_sync_len;
        obs_tab[8] = {31'd0, hsync_pol};
        obs_tab[9] = {31'd0, vsync_pol};
    end

    int checks   = 0;
    int failures = 0;
    int model_mode = 0;

    // Frame source with random active/blank lengths; hold_low freezes it in blanking.
    logic hold_low = 1'b0;
    initial begin : video_src
        int n_act;
        int n_blk;
        vert_active  = 1'b0;
        rgb_red_in   = 4'h1;
        rgb_green_in = 4'h1;
        rgb_blue_in  = 4'h1;
        forever begin
            n_act = $urandom_range(40, 20);
            n_blk = $urandom_range(20, 6);
            for (int i = 0; i < n_act + n_blk; i++) begin
                @(posedge pxl_clk);
                #1;
                vert_active  = (i < n_act) && !hold_low;
                rgb_red_in   = 4'($urandom_range(15, 1));
                rgb_green_in = 4'($urandom_range(15, 1));
                rgb_blue_in  = 4'($urandom_range(15, 1));
            end
        end
    end

    // Edge counter and record of edges at which vert_active is first seen low.
    int   cyc = 0;
    logic prev_va = 1'b0;
    int   falls [$];
    always @(posedge pxl_clk) begin
        cyc++;
        if (prev_va && !vert_active) falls.push_back(cyc);
        prev_va = vert_active;
    end

    initial begin : watchdog
        #(40 * 60000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    task automatic do_request(input logic [1:0] m, output int a_edge);
        @(negedge pxl_clk);
        mode_sel = m;
        mode_req = 1'b1;
        @(negedge pxl_clk);
        mode_req = 1'b0;
        a_edge = cyc;
    endtask

    task automatic wait_active();
        for (int i = 0; i < 200 && vert_active !== 1'b1; i++) @(negedge pxl_clk);
        repeat ($urandom_range(5, 0)) @(negedge pxl_clk);
    endtask

    task automatic test_reset();
        pxl_rst  = 1'b1;
        mode_req = 1'b0;
        mode_sel = 2'd0;
        repeat (4) @(negedge pxl_clk);
        checks++;
        if (core_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_core_rst: got %b expected 1", core_rst);
        end
        checks++;
        if ({mode_ack, mode_nack, mode_busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_handshake: got ack/nack/busy=%b expected 000", {mode_ack, mode_nack, mode_busy});
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_tab[i] !== exp_tab[0][i]) begin
                failures++;
                $display("FAIL reset_%s: got %0d expected %0d", fld_name[i], obs_tab[i], exp_tab[0][i]);
            end
        end
        checks++;
        if (cur_mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_cur_mode: got %0d expected 0", cur_mode);
        end
        checks++;
        if ({rgb_red, rgb_green, rgb_blue} !== {rgb_red_in, rgb_green_in, rgb_blue_in}) begin
            failures++;
            $display("FAIL reset_rgb_pass: got %h expected %h", {rgb_red, rgb_green, rgb_blue}, {rgb_red_in, rgb_green_in, rgb_blue_in});
        end
        pxl_rst = 1'b0;
        @(negedge pxl_clk);
        checks++;
        if (core_rst !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_core_rst: got %b expected 0", core_rst);
        end
        model_mode = 0;
    endtask

    // Full mode switch; with inject set, a second request is issued during blanking.
    task automatic test_switch(input int target, input bit inject, input string tag);
        int a, first_blank, t_change, rst_first, rst_cnt, ack_cyc, ack_cnt;
        int nack_cnt, nack_cyc, inj_edge, gate_err, busy_err, extra;
        int e_blank, e_load, e_ack;
        logic blanked, blank_at_ack;
        logic [31:0] old_vres;
        int f [$];
        first_blank = -1; t_change = -1; rst_first = -1; rst_cnt = 0;
        ack_cyc = -1; ack_cnt = 0; nack_cnt = 0; nack_cyc = -1; inj_edge = -1;
        gate_err = 0; busy_err = 0; extra = 0; blank_at_ack = 1'b1;
        old_vres = exp_tab[model_mode][4];
        wait_active();
        falls.delete();
        do_request(2'(target), a);
        for (int k = 0; k < 3000 && extra < 5; k++) begin
            if (k > 0) @(negedge pxl_clk);
            mode_req = 1'b0;
            blanked = ({rgb_red, rgb_green, rgb_blue} === 12'h000);
            if (!blanked && ({rgb_red, rgb_green, rgb_blue} !== {rgb_red_in, rgb_green_in, rgb_blue_in})) gate_err++;
            if (blanked && first_blank < 0) first_blank = cyc;
            if (vert_res !== old_vres && t_change < 0) t_change = cyc;
            if (core_rst === 1'b1) begin
                if (rst_first < 0) rst_first = cyc;
                rst_cnt++;
            end
            if (mode_ack === 1'b1) begin
                ack_cnt++;
                ack_cyc = cyc;
                blank_at_ack = blanked;
                if (mode_busy !== 1'b0) busy_err++;
            end
            if (mode_nack === 1'b1) begin
                nack_cnt++;
                nack_cyc = cyc;
            end
            if (ack_cnt == 0 && mode_busy !== 1'b1) busy_err++;
            if (ack_cnt > 0) extra++;
            if (inject && inj_edge < 0 && first_blank >= 0 && cyc == first_blank + 3) begin
                mode_sel = 2'($urandom_range(3, 0));
                mode_req = 1'b1;
                inj_edge = cyc + 1;
            end
        end
        foreach (falls[i]) if (falls[i] > a) f.push_back(falls[i]);
        checks++;
        if (f.size() < BLANK_N + 2) begin
            failures++;
            $display("FAIL %s_frames: got %0d frame ends expected at least %0d", tag, f.size(), BLANK_N + 2);
        end else begin
            e_blank = f[0];
            e_load  = f[BLANK_N] + 1;
            e_ack   = -1;
            foreach (f[i]) if (e_ack < 0 && f[i] >= e_load + SETTLE_N + 1) e_ack = f[i];
            checks++;
            if (first_blank != e_blank) begin
                failures++;
                $display("FAIL %s_blank_start: got cycle %0d expected %0d", tag, first_blank, e_blank);
            end
            checks++;
            if (t_change != e_load) begin
                failures++;
                $display("FAIL %s_timing_load: got cycle %0d expected %0d", tag, t_change, e_load);
            end
            checks++;
            if (rst_first != e_load) begin
                failures++;
                $display("FAIL %s_core_rst_start: got cycle %0d expected %0d", tag, rst_first, e_load);
            end
            checks++;
            if (ack_cyc != e_ack) begin
                failures++;
                $display("FAIL %s_ack_cycle: got %0d expected %0d", tag, ack_cyc, e_ack);
            end
        end
        checks++;
        if (rst_cnt != SETTLE_N) begin
            failures++;
            $display("FAIL %s_core_rst_len: got %0d expected %0d", tag, rst_cnt, SETTLE_N);
        end
        checks++;
        if (ack_cnt != 1) begin
            failures++;
            $display("FAIL %s_ack_count: got %0d expected 1", tag, ack_cnt);
        end
        checks++;
        if (gate_err != 0 || blank_at_ack !== 1'b0) begin
            failures++;
            $display("FAIL %s_rgb_gate: got %0d gating errors, blank_at_ack=%b expected 0 and 0", tag, gate_err, blank_at_ack);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s_busy: got %0d busy errors expected 0", tag, busy_err);
        end
        checks++;
        if (inject ? (nack_cnt != 1 || nack_cyc != inj_edge) : (nack_cnt != 0)) begin
            failures++;
            $display("FAIL %s_nack: got %0d pulses at %0d expected %0d at %0d", tag, nack_cnt, nack_cyc, inject ? 1 : 0, inj_edge);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_tab[i] !== exp_tab[target][i]) begin
                failures++;
                $display("FAIL %s_%s: got %0d expected %0d", tag, fld_name[i], obs_tab[i], exp_tab[target][i]);
            end
        end
        checks++;
        if (cur_mode !== 2'(target)) begin
            failures++;
            $display("FAIL %s_cur_mode: got %0d expected %0d", tag, cur_mode, target);
        end
        model_mode = target;
    endtask

    // Invalid index (3) or already-active index: immediate nack/ack, no blanking.
    task automatic test_immediate(input int sel, input string tag);
        int a, ack_cnt, nack_cnt, blank_cnt, busy_cnt, ack_at_a, nack_at_a;
        ack_cnt = 0; nack_cnt = 0; blank_cnt = 0; busy_cnt = 0;
        do_request(2'(sel), a);
        ack_at_a  = int'(mode_ack);
        nack_at_a = int'(mode_nack);
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge pxl_clk);
            if (mode_ack === 1'b1) ack_cnt++;
            if (mode_nack === 1'b1) nack_cnt++;
            if ({rgb_red, rgb_green, rgb_blue} !== {rgb_red_in, rgb_green_in, rgb_blue_in}) blank_cnt++;
            if (mode_busy !== 1'b0 || core_rst !== 1'b0) busy_cnt++;
        end
        checks++;
        if (sel == 3 ? (nack_at_a != 1 || nack_cnt != 1 || ack_cnt != 0)
                     : (ack_at_a != 1 || ack_cnt != 1 || nack_cnt != 0)) begin
            failures++;
            $display("FAIL %s_handshake: got ack@a=%0d nack@a=%0d acks=%0d nacks=%0d expected single %s pulse",
                     tag, ack_at_a, nack_at_a, ack_cnt, nack_cnt, sel == 3 ? "nack" : "ack");
        end
        checks++;
        if (blank_cnt != 0 || busy_cnt != 0) begin
            failures++;
            $display("FAIL %s_quiet: got %0d blank and %0d busy/core_rst cycles expected 0", tag, blank_cnt, busy_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_tab[i] !== exp_tab[model_mode][i]) begin
                failures++;
                $display("FAIL %s_%s: got %0d expected %0d", tag, fld_name[i], obs_tab[i], exp_tab[model_mode][i]);
            end
        end
        checks++;
        if (cur_mode !== 2'(model_mode)) begin
            failures++;
            $display("FAIL %s_cur_mode: got %0d expected %0d", tag, cur_mode, model_mode);
        end
    endtask

    // Frames stopped: the switch is forced after the timeout; reset then lands mid-settle.
    task automatic test_timeout_reset();
        int a, target, first_blank, t_change, rst_first, hs_cnt, bad_cnt;
        target = (model_mode == 1) ? 2 : 1;
        first_blank = -1; t_change = -1; rst_first = -1; hs_cnt = 0; bad_cnt = 0;
        hold_low = 1'b1;
        repeat (4) @(negedge pxl_clk);
        do_request(2'(target), a);
        while (cyc < a + TIMEOUT_N + 6) begin
            if ({rgb_red, rgb_green, rgb_blue} === 12'h000 && first_blank < 0) first_blank = cyc;
            if (vert_res !== exp_tab[model_mode][4] && t_change < 0) t_change = cyc;
            if (core_rst === 1'b1 && rst_first < 0) rst_first = cyc;
            if (mode_ack === 1'b1 || mode_nack === 1'b1) hs_cnt++;
            @(negedge pxl_clk);
        end
        checks++;
        if (first_blank != a + TIMEOUT_N) begin
            failures++;
            $display("FAIL timeout_blank: got cycle %0d expected %0d", first_blank, a + TIMEOUT_N);
        end
        checks++;
        if (t_change != a + TIMEOUT_N + 1 || rst_first != a + TIMEOUT_N + 1) begin
            failures++;
            $display("FAIL timeout_load: got load %0d core_rst %0d expected %0d", t_change, rst_first, a + TIMEOUT_N + 1);
        end
        checks++;
        if (vert_res !== exp_tab[target][4] || cur_mode !== 2'(target)) begin
            failures++;
            $display("FAIL timeout_mode: got vert_res %0d cur_mode %0d expected %0d and %0d", vert_res, cur_mode, exp_tab[target][4], target);
        end
        pxl_rst = 1'b1;
        @(negedge pxl_clk);
        checks++;
        if (core_rst !== 1'b1) begin
            failures++;
            $display("FAIL settle_reset_core_rst: got %b expected 1", core_rst);
        end
        @(negedge pxl_clk);
        pxl_rst  = 1'b0;
        hold_low = 1'b0;
        model_mode = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge pxl_clk);
            if (mode_ack === 1'b1 || mode_nack === 1'b1) hs_cnt++;
            if ({rgb_red, rgb_green, rgb_blue} !== {rgb_red_in, rgb_green_in, rgb_blue_in}) bad_cnt++;
            if (mode_busy !== 1'b0 || core_rst !== 1'b0) bad_cnt++;
        end
        checks++;
        if (hs_cnt != 0 || bad_cnt != 0) begin
            failures++;
            $display("FAIL settle_reset_quiet: got %0d handshakes %0d bad cycles expected 0 and 0", hs_cnt, bad_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs_tab[i] !== exp_tab[0][i]) begin
                failures++;
                $display("FAIL settle_reset_%s: got %0d expected %0d", fld_name[i], obs_tab[i], exp_tab[0][i]);
            end
        end
        checks++;
        if (cur_mode !== 2'd0) begin
            failures++;
            $display("FAIL settle_reset_cur_mode: got %0d expected 0", cur_mode);
        end
    endtask

    initial begin : main
        test_reset();
        repeat (10) @(negedge pxl_clk);
        test_switch(1, 1'b0, "switch_to_1");
        test_immediate(3, "invalid");
        test_immediate(model_mode, "same_mode");
        test_switch((model_mode + int'($urandom_range(2, 1))) % 3, 1'b1, "back_to_back");
        for (int r = 0; r < 3; r++) begin
            test_switch((model_mode + int'($urandom_range(2, 1))) % 3, 1'b0, "random_switch");
        end
        test_immediate(3, "invalid_after");
        test_timeout_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
